wg_slot_table_v2: RTL and testbench
===================================

// Module: wg_slot_table_v2
// PURPOSE
//  Per-CU workgroup slot and wavefront-capacity table for the dispatcher. It is
//  the parametrised successor of the earlier WG resource table.
//  Serves one alloc/dealloc request at a time over a valid/ready handshake and
//  returns a response: slot id, fail flag and the CU's updated WF usage.
//  Adds over-capacity and duplicate/unknown-WG rejection, and a post-reset
//  clearing sweep that replaces per-CU "initialized" bits.
//  Also keeps the per-group inflight free-WF table read by the allocator.
// PARAMETERS
//  NUMBER_CU            64  number of compute units
//  CU_ID_WIDTH          6   CU index width
//  WG_ID_WIDTH          10  workgroup id width; map depth is 2**WG_ID_WIDTH
//  WF_COUNT_WIDTH       4   per-request wavefront count width
//  NUMBER_WG_SLOTS      40  WG slots per CU (bitmap width)
//  WG_SLOT_ID_WIDTH     6   slot index width
//  NUMBER_WF_SLOTS      40  WF capacity per CU
//  WF_USED_WIDTH        6   usage counter width; must hold NUMBER_WF_SLOTS
//  RES_TABLE_ADDR_WIDTH 3   inflight table index = top bits of cu_id
// PORTS
//  clk                 in   1   clock
//  rst                 in   1   reset, asynchronous, active-high
//  req_valid           in   1   request present
//  req_ready           out  1   request accepted when valid & ready
//  req_op              in   1   0 = alloc, 1 = dealloc
//  req_cu_id           in   CU_ID_WIDTH       target CU
//  req_wg_id           in   WG_ID_WIDTH       workgroup id
//  req_wf_count        in   WF_COUNT_WIDTH    WFs to allocate (ignored on dealloc)
//  rsp_valid           out  1   one-cycle response strobe
//  rsp_fail            out  1   request rejected; no state changed
//  rsp_wg_slot_id      out  WG_SLOT_ID_WIDTH  allocated/freed slot (0 on fail)
//  rsp_cu_wf_used      out  WF_USED_WIDTH     CU usage after the operation
//  init_done           out  1   clearing sweep complete
//  inflight_tbl_id     in   RES_TABLE_ADDR_WIDTH  inflight read address
//  inflight_free_count out  WF_USED_WIDTH     NUMBER_WF_SLOTS - used, 1-cycle read
// BEHAVIOUR
//  Storage
//   - Slot bitmap and wf_used, each per CU.
//   - WG map per wg_id: {valid, cu_id, slot, wf_count}.
//   - Inflight ram per CU group.
//  Reset: all outputs 0, FSM -> INIT.
//   - rst mid-operation aborts the op; no response is issued.
//  INIT: the sweep counter writes 0 to every bitmap/wf_used/inflight/map entry,
//   one index per cycle, for max(NUMBER_CU, 2**WG_ID_WIDTH) cycles.
//   - Inflight entries are written NUMBER_WF_SLOTS.
//   - Then init_done=1 (held until reset) and FSM -> IDLE.
//  FSM: IDLE -> READ -> CALC -> WRITE -> IDLE.
//   - req_ready=1 only in IDLE with init_done=1.
//   - Accept at cycle T: ram reads registered at T+1, compute at T+2,
//     writes plus rsp_valid at T+3.
//   - Next accept no earlier than T+4.
//  Alloc
//   - Slot = lowest-index clear bitmap bit.
//   - Sum = wf_used + req_wf_count, computed in WF_USED_WIDTH+1 bits.
//   - Fail if: no clear bit, sum > NUMBER_WF_SLOTS, req_wf_count==0,
//     or map[wg_id].valid==1.
//   - Otherwise: set the bit, wf_used = sum, write map entry with valid=1.
//  Dealloc
//   - Fail if map[wg_id].valid==0 or map cu_id != req_cu_id.
//   - Otherwise: clear the bitmap bit at map slot,
//     wf_used -= map wf_count (saturate at 0), map valid=0.
//  Inflight ram: on every successful op, write NUMBER_WF_SLOTS - new wf_used
//   at cu_id[CU_ID_WIDTH-1 -: RES_TABLE_ADDR_WIDTH].
//   - The ram is read every cycle.
//   - Read and write to the same address in one cycle returns the old data.
//  Fail response: rsp_wg_slot_id=0 and rsp_cu_wf_used = unchanged usage.
//  Response outputs hold their value until the next rsp_valid.
// TESTING
//  1 Reset, then idle -> init_done=0 and req_ready=0 for 1024 cycles, then both 1.
//  2 alloc cu5 wg7 cnt4, then alloc cu5 wg8 cnt3 -> rsp_valid at T+3:
//    slot0/used4, then slot1/used7; rsp_fail=0.
//  3 dealloc cu5 wg7, then alloc cu5 wg9 cnt2 -> slot0/used3, then slot0/used5.
//  4 ten allocs cnt4 on cu2, then alloc cnt1 -> used40, then fail with used40;
//    dealloc wg999 (never allocated) -> fail; repeat alloc of a valid wg -> fail.
//  5 alloc cu9 cnt5, then inflight_tbl_id=1 -> inflight_free_count=35 next cycle.
//  6 rst pulsed while in CALC -> no rsp_valid, INIT reruns,
//    a prior wg's dealloc fails afterwards.

Source files
------------

// File: rtl/wg_slot_table_v2.sv
// -----------------------------------------------------------------------------
// wg_slot_table_v2
//
// Per-CU workgroup slot and wavefront-capacity table for the dispatcher.
// One alloc/dealloc request is in flight at a time. Each request walks
// IDLE -> READ -> CALC -> WRITE and produces a single-cycle response carrying
// the slot id, a fail flag and the CU's WF usage after the operation.
// After every reset a clearing sweep zeroes all tables, one index per cycle,
// before the first request is accepted.
// A small per-CU-group table holds the free WF count of the most recently
// updated CU in each group, for the allocator.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE after sweep)
//   req_op                0 = alloc, 1 = dealloc
//   req_cu_id             target CU
//   req_wg_id             workgroup id
//   req_wf_count          WFs to allocate (ignored on dealloc)
//   rsp_valid             one-cycle response strobe
//   rsp_fail              request rejected, no state changed
//   rsp_wg_slot_id        allocated/freed slot, 0 on fail
//   rsp_cu_wf_used        CU usage after the operation
//   init_done             clearing sweep finished
//   inflight_tbl_id       inflight table read address
//   inflight_free_count   registered read of the inflight table
// -----------------------------------------------------------------------------
module wg_slot_table_v2 #(
    parameter int NUMBER_CU            = 64,
    parameter int CU_ID_WIDTH          = 6,
    parameter int WG_ID_WIDTH          = 10,
    parameter int WF_COUNT_WIDTH       = 4,
    parameter int NUMBER_WG_SLOTS      = 40,
    parameter int WG_SLOT_ID_WIDTH     = 6,
    parameter int NUMBER_WF_SLOTS      = 40,
    parameter int WF_USED_WIDTH        = 6,
    parameter int RES_TABLE_ADDR_WIDTH = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_op,
    input  logic [CU_ID_WIDTH-1:0]          req_cu_id,
    input  logic [WG_ID_WIDTH-1:0]          req_wg_id,
    input  logic [WF_COUNT_WIDTH-1:0]       req_wf_count,
    output logic                            rsp_valid,
    output logic                            rsp_fail,
    output logic [WG_SLOT_ID_WIDTH-1:0]     rsp_wg_slot_id,
    output logic [WF_USED_WIDTH-1:0]        rsp_cu_wf_used,
    output logic                            init_done,
    input  logic [RES_TABLE_ADDR_WIDTH-1:0] inflight_tbl_id,
    output logic [WF_USED_WIDTH-1:0]        inflight_free_count
);

    localparam int WG_DEPTH    = 2 ** WG_ID_WIDTH;
    localparam int TBL_DEPTH   = 2 ** RES_TABLE_ADDR_WIDTH;
    localparam int SWEEP_DEPTH = (NUMBER_CU > WG_DEPTH) ? NUMBER_CU : WG_DEPTH;
    localparam int SWEEP_W     = $clog2(SWEEP_DEPTH);
    localparam int SUM_W       = WF_USED_WIDTH + 1;

    localparam logic OP_ALLOC = 1'b0;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_READ,
        S_CALC,
        S_WRITE
    } state_t;

    typedef struct packed {
        logic                        valid;
        logic [CU_ID_WIDTH-1:0]      cu_id;
        logic [WG_SLOT_ID_WIDTH-1:0] slot;
        logic [WF_COUNT_WIDTH-1:0]   wf_count;
    } map_entry_t;

    // ---------------------------------------------------------------- storage
    logic [NUMBER_WG_SLOTS-1:0] slot_bitmap [NUMBER_CU];
    logic [WF_USED_WIDTH-1:0]   wf_used     [NUMBER_CU];
    map_entry_t                 wg_map      [WG_DEPTH];
    logic [WF_USED_WIDTH-1:0]   inflight    [TBL_DEPTH];

    // ------------------------------------------------------------ FSM state
    state_t                     state;
    logic [SWEEP_W-1:0]         sweep_cnt;

    // request captured at accept
    logic                       q_op;
    logic [CU_ID_WIDTH-1:0]     q_cu_id;
    logic [WG_ID_WIDTH-1:0]     q_wg_id;
    logic [WF_COUNT_WIDTH-1:0]  q_wf_count;

    // table reads registered in READ
    logic [NUMBER_WG_SLOTS-1:0] rd_bitmap;
    logic [WF_USED_WIDTH-1:0]   rd_used;
    map_entry_t                 rd_map;

    // results registered in CALC, committed in WRITE
    logic                       commit;
    logic [NUMBER_WG_SLOTS-1:0] wr_bitmap;
    logic [WF_USED_WIDTH-1:0]   wr_used;
    logic [WF_USED_WIDTH-1:0]   wr_free;
    map_entry_t                 wr_map;

    // ------------------------------------------------------- combinational
    logic                        free_found;
    logic [WG_SLOT_ID_WIDTH-1:0] free_idx;
    logic [SUM_W-1:0]            sum;
    logic                        calc_fail;
    logic [WG_SLOT_ID_WIDTH-1:0] calc_slot;
    logic [NUMBER_WG_SLOTS-1:0]  calc_bitmap;
    logic [WF_USED_WIDTH-1:0]    calc_used;
    map_entry_t                  calc_map;

    // Lowest clear bit: scan downward so the last hit is the lowest index.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUMBER_WG_SLOTS - 1; i >= 0; i--) begin
            if (!rd_bitmap[i]) begin
                free_found = 1'b1;
                free_idx   = WG_SLOT_ID_WIDTH'(i);
            end
        end
    end

    always_comb begin
        // one extra bit so an overflowing sum still compares correctly
        sum         = {1'b0, rd_used} + SUM_W'(q_wf_count);
        calc_fail   = 1'b0;
        calc_slot   = '0;
        calc_bitmap = rd_bitmap;
        calc_used   = rd_used;
        calc_map    = '0;
        if (q_op == OP_ALLOC) begin
            calc_fail = !free_found
                     || (sum > SUM_W'(NUMBER_WF_SLOTS))
                     || (q_wf_count == '0)
                     || rd_map.valid;
            calc_slot = free_idx;
            calc_used = sum[WF_USED_WIDTH-1:0];
            for (int i = 0; i < NUMBER_WG_SLOTS; i++) begin
                if (WG_SLOT_ID_WIDTH'(i) == free_idx) calc_bitmap[i] = 1'b1;
            end
            calc_map.valid    = 1'b1;
            calc_map.cu_id    = q_cu_id;
            calc_map.slot     = free_idx;
            calc_map.wf_count = q_wf_count;
        end else begin
            calc_fail = !rd_map.valid || (rd_map.cu_id != q_cu_id);
            calc_slot = rd_map.slot;
            // saturate instead of wrapping if the counter ever disagrees
            calc_used = (rd_used > WF_USED_WIDTH'(rd_map.wf_count))
                      ? rd_used - WF_USED_WIDTH'(rd_map.wf_count) : '0;
            for (int i = 0; i < NUMBER_WG_SLOTS; i++) begin
                if (WG_SLOT_ID_WIDTH'(i) == rd_map.slot) calc_bitmap[i] = 1'b0;
            end
            // calc_map stays all-zero: the map entry is invalidated
        end
    end

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_INIT;
            sweep_cnt      <= '0;
            init_done      <= 1'b0;
            req_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_fail       <= 1'b0;
            rsp_wg_slot_id <= '0;
            rsp_cu_wf_used <= '0;
            q_op           <= 1'b0;
            q_cu_id        <= '0;
            q_wg_id        <= '0;
            q_wf_count     <= '0;
            rd_bitmap      <= '0;
            rd_used        <= '0;
            rd_map         <= '0;
            commit         <= 1'b0;
            wr_bitmap      <= '0;
            wr_used        <= '0;
            wr_free        <= '0;
            wr_map         <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_INIT: begin
                    if (sweep_cnt == SWEEP_W'(SWEEP_DEPTH - 1)) begin
                        init_done <= 1'b1;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        sweep_cnt <= sweep_cnt + SWEEP_W'(1);
                    end
                end
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        q_op       <= req_op;
                        q_cu_id    <= req_cu_id;
                        q_wg_id    <= req_wg_id;
                        q_wf_count <= req_wf_count;
                        req_ready  <= 1'b0;
                        state      <= S_READ;
                    end
                end
                S_READ: begin
                    rd_bitmap <= slot_bitmap[q_cu_id];
                    rd_used   <= wf_used[q_cu_id];
                    rd_map    <= wg_map[q_wg_id];
                    state     <= S_CALC;
                end
                S_CALC: begin
                    rsp_valid      <= 1'b1;
                    rsp_fail       <= calc_fail;
                    rsp_wg_slot_id <= calc_fail ? '0 : calc_slot;
                    rsp_cu_wf_used <= calc_fail ? rd_used : calc_used;
                    commit         <= !calc_fail;
                    wr_bitmap      <= calc_bitmap;
                    wr_used        <= calc_used;
                    wr_free        <= WF_USED_WIDTH'(NUMBER_WF_SLOTS) - calc_used;
                    wr_map         <= calc_map;
                    state          <= S_WRITE;
                end
                S_WRITE: begin
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_INIT;
            endcase
        end
    end

    // --------------------------------------------------------- table writes
    // Tables carry no reset; the sweep clears them instead. An async reset
    // forces state to INIT, so a WRITE cut short by reset never commits.
    logic sweep_we;
    logic commit_we;

    assign sweep_we  = (state == S_INIT);
    assign commit_we = (state == S_WRITE) && commit;

    always_ff @(posedge clk) begin
        if (sweep_we) begin
            if (int'(sweep_cnt) < NUMBER_CU) begin
                slot_bitmap[sweep_cnt[CU_ID_WIDTH-1:0]] <= '0;
                wf_used[sweep_cnt[CU_ID_WIDTH-1:0]]     <= '0;
            end
            if (int'(sweep_cnt) < TBL_DEPTH) begin
                inflight[sweep_cnt[RES_TABLE_ADDR_WIDTH-1:0]] <= WF_USED_WIDTH'(NUMBER_WF_SLOTS);
            end
            if (int'(sweep_cnt) < WG_DEPTH) begin
                wg_map[sweep_cnt[WG_ID_WIDTH-1:0]] <= '0;
            end
        end else if (commit_we) begin
            slot_bitmap[q_cu_id] <= wr_bitmap;
            wf_used[q_cu_id]     <= wr_used;
            wg_map[q_wg_id]      <= wr_map;
            // group index is the top bits of the CU id
            inflight[q_cu_id[CU_ID_WIDTH-1 -: RES_TABLE_ADDR_WIDTH]] <= wr_free;
        end
    end

    // Read every cycle; a same-cycle write to the same entry returns old data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) inflight_free_count <= '0;
        else     inflight_free_count <= inflight[inflight_tbl_id];
    end

endmodule

// File: tb/tb_wg_slot_table_v2.sv
`timescale 1ns/1ps
module tb_wg_slot_table_v2;

    localparam int NCU = 64;
    localparam int CUW = 6;
    localparam int WGW = 10;
    localparam int CW  = 4;
    localparam int NSL = 40;
    localparam int SLW = 6;
    localparam int NWF = 40;
    localparam int UW  = 6;
    localparam int TW  = 3;
    localparam int NWG = 1 << WGW;
    localparam int NGR = 1 << TW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic           req_op = 1'b0;
    logic [CUW-1:0] req_cu_id = '0;
    logic [WGW-1:0] req_wg_id = '0;
    logic [CW-1:0]  req_wf_count = '0;
    logic           rsp_valid;
    logic           rsp_fail;
    logic [SLW-1:0] rsp_wg_slot_id;
    logic [UW-1:0]  rsp_cu_wf_used;
    logic           init_done;
    logic [TW-1:0]  inflight_tbl_id = '0;
    logic [UW-1:0]  inflight_free_count;

    int  n_pass  = 0;
    int  n_total = 0;
    time acc_time;

    always #5 clk = ~clk;

    wg_slot_table_v2 #(
        .NUMBER_CU(NCU), .CU_ID_WIDTH(CUW), .WG_ID_WIDTH(WGW),
        .WF_COUNT_WIDTH(CW), .NUMBER_WG_SLOTS(NSL), .WG_SLOT_ID_WIDTH(SLW),
        .NUMBER_WF_SLOTS(NWF), .WF_USED_WIDTH(UW), .RES_TABLE_ADDR_WIDTH(TW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_cu_id(req_cu_id), .req_wg_id(req_wg_id), .req_wf_count(req_wf_count),
        .rsp_valid(rsp_valid), .rsp_fail(rsp_fail),
        .rsp_wg_slot_id(rsp_wg_slot_id), .rsp_cu_wf_used(rsp_cu_wf_used),
        .init_done(init_done), .inflight_tbl_id(inflight_tbl_id),
        .inflight_free_count(inflight_free_count)
    );

    // ------------------------------------------------------ reference model
    bit m_occ  [NCU][NSL];
    int m_used [NCU];
    bit m_wv   [NWG];
    int m_wcu  [NWG];
    int m_wsl  [NWG];
    int m_wcnt [NWG];
    int m_infl [NGR];

    function automatic void model_clear();
        for (int c = 0; c < NCU; c++) begin
            m_used[c] = 0;
            for (int s = 0; s < NSL; s++) m_occ[c][s] = 1'b0;
        end
        for (int w = 0; w < NWG; w++) m_wv[w] = 1'b0;
        for (int g = 0; g < NGR; g++) m_infl[g] = NWF;
    endfunction

    function automatic void model_op(input bit op, input int cu, input int wg, input int cnt,
                                     output bit f, output int slot, output int used);
        f = 1'b0;
        slot = 0;
        if (!op) begin
            int fs = -1;
            for (int s = 0; s < NSL; s++) if (!m_occ[cu][s]) begin fs = s; break; end
            if (fs < 0 || m_used[cu] + cnt > NWF || cnt == 0 || m_wv[wg]) f = 1'b1;
            else begin
                m_occ[cu][fs] = 1'b1;
                m_used[cu] += cnt;
                m_wv[wg] = 1'b1; m_wcu[wg] = cu; m_wsl[wg] = fs; m_wcnt[wg] = cnt;
                slot = fs;
            end
        end else begin
            if (!m_wv[wg] || m_wcu[wg] != cu) f = 1'b1;
            else begin
                slot = m_wsl[wg];
                m_occ[cu][slot] = 1'b0;
                m_used[cu] = (m_used[cu] > m_wcnt[wg]) ? m_used[cu] - m_wcnt[wg] : 0;
                m_wv[wg] = 1'b0;
            end
        end
        if (!f) m_infl[cu / 8] = NWF - m_used[cu];
        used = m_used[cu];
    endfunction

    // Drives one request, returns once rsp_valid is seen (#1 after that edge).
    // lat = edges after the accept edge until rsp_valid; 2 means the response
    // sits in the third cycle after the accept cycle.
    task automatic do_req(input bit op, input int cu, input int wg, input int cnt,
                          output bit ok, output int lat);
        int guard = 0;
        ok  = 1'b1;
        lat = 0;
        req_valid = 1'b1; req_op = op;
        req_cu_id = CUW'(cu); req_wg_id = WGW'(wg); req_wf_count = CW'(cnt);
        while (req_ready !== 1'b1 && guard < 50) begin @(posedge clk); #1; guard++; end
        if (guard >= 50) begin req_valid = 1'b0; ok = 1'b0; return; end
        @(posedge clk);
        acc_time = $time;
        #1 req_valid = 1'b0;
        while (rsp_valid !== 1'b1 && lat < 8) begin @(posedge clk); #1; lat++; end
        if (lat >= 8) ok = 1'b0;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        bit low_ok = 1'b1;
        rst = 1'b1; req_valid = 1'b0; inflight_tbl_id = 3'd3;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({rsp_valid, rsp_fail, rsp_wg_slot_id, rsp_cu_wf_used, init_done, req_ready, inflight_free_count} !== '0)
            $display("FAIL reset_outputs got v=%0b f=%0b s=%0d u=%0d id=%0b rdy=%0b ifc=%0d exp all 0",
                     rsp_valid, rsp_fail, rsp_wg_slot_id, rsp_cu_wf_used, init_done, req_ready, inflight_free_count);
        else n_pass++;
        rst = 1'b0;
        for (int i = 0; i < 1023; i++) begin
            @(posedge clk); #1;
            if (init_done !== 1'b0 || req_ready !== 1'b0) low_ok = 1'b0;
        end
        n_total++;
        if (!low_ok) $display("FAIL init_early got init_done/req_ready high within 1023 cycles exp low");
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if ({init_done, req_ready} !== 2'b11)
            $display("FAIL init_done got %0b%0b exp 11", init_done, req_ready);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (inflight_free_count !== UW'(NWF))
            $display("FAIL init_inflight got %0d exp %0d", inflight_free_count, NWF);
        else n_pass++;
        model_clear();
    endtask

    task automatic test_alloc_basic();
        int wg[2] = '{7, 8};
        int cn[2] = '{4, 3};
        int es[2] = '{0, 1};
        int eu[2] = '{4, 7};
        bit ok, mf; int lat, ms, mu;
        for (int i = 0; i < 2; i++) begin
            model_op(1'b0, 5, wg[i], cn[i], mf, ms, mu);
            do_req(1'b0, 5, wg[i], cn[i], ok, lat);
            n_total++;
            if (!ok || lat != 2 || {rsp_fail, rsp_wg_slot_id, rsp_cu_wf_used} !== {1'b0, SLW'(es[i]), UW'(eu[i])})
                $display("FAIL alloc_basic[%0d] got ok=%0b lat=%0d f=%0b s=%0d u=%0d exp lat=2 f=0 s=%0d u=%0d",
                         i, ok, lat, rsp_fail, rsp_wg_slot_id, rsp_cu_wf_used, es[i], eu[i]);
            else n_pass++;
        end
    endtask

    task automatic test_dealloc();
        bit op[2] = '{1'b1, 1'b0};
        int wg[2] = '{7, 9};
        int cn[2] = '{0, 2};
        int eu[2] = '{3, 5};
        bit ok, mf; int lat, ms, mu;
        for (int i = 0; i < 2; i++) begin
            model_op(op[i], 5, wg[i], cn[i], mf, ms, mu);
            do_req(op[i], 5, wg[i], cn[i], ok, lat);
            n_total++;
            if (!ok || lat != 2 || {rsp_fail, rsp_wg_slot_id, rsp_cu_wf_used} !== {1'b0, SLW'(0), UW'(eu[i])})
                $display("FAIL dealloc[%0d] got ok=%0b lat=%0d f=%0b s=%0d u=%0d exp lat=2 f=0 s=0 u=%0d",
                         i, ok, lat, rsp_fail, rsp_wg_slot_id, rsp_cu_wf_used, eu[i]);
            else n_pass++;
        end
    endtask

    task automatic test_capacity();
        bit op[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        int cu[9] = '{2, 2, 3, 3, 3, 2, 2, 2, 2};
        int wg[9] = '{110, 999, 100, 111, 101, 104, 113, 110, 112};
        int cn[9] = '{1, 0, 1, 0, 0, 0, 5, 4, 1};
        bit ef[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        int es[9] = '{0, 0, 0, 0, 0, 4, 0, 4, 0};
        int eu[9] = '{40, 40, 0, 0, 0, 36, 36, 40, 40};
        bit ok, mf; int lat, ms, mu;
        for (int i = 0; i < 10; i++) begin
            model_op(1'b0, 2, 100 + i, 4, mf, ms, mu);
            do_req(1'b0, 2, 100 + i, 4, ok, lat);
            n_total++;
            if (!ok || {rsp_fail, rsp_wg_slot_id, rsp_cu_wf_used} !== {1'b0, SLW'(i), UW'(4 * (i + 1))})
                $display("FAIL fill[%0d] got ok=%0b f=%0b s=%0d u=%0d exp f=0 s=%0d u=%0d",
                         i, ok, rsp_fail, rsp_wg_slot_id, rsp_cu_wf_used, i, 4 * (i + 1));
            else n_pass++;
        end
        for (int i = 0; i < 9; i++) begin
            model_op(op[i], cu[i], wg[i], cn[i], mf, ms, mu);
            do_req(op[i], cu[i], wg[i], cn[i], ok, lat);
            n_total++;
            if (!ok || {rsp_fail, rsp_wg_slot_id, rsp_cu_wf_used} !== {ef[i], SLW'(es[i]), UW'(eu[i])})
                $display("FAIL capacity[%0d] got ok=%0b f=%0b s=%0d u=%0d exp f=%0b s=%0d u=%0d",
                         i, ok, rsp_fail, rsp_wg_slot_id, rsp_cu_wf_used, ef[i], es[i], eu[i]);
            else n_pass++;
        end
    endtask

    task automatic test_inflight();
        bit ok, mf; int lat, ms, mu;
        int old_free = m_infl[1];
        model_op(1'b0, 9, 300, 5, mf, ms, mu);
        do_req(1'b0, 9, 300, 5, ok, lat);
        n_total++;
        if (!ok || {rsp_fail, rsp_wg_slot_id, rsp_cu_wf_used} !== {1'b0, SLW'(0), UW'(5)})
            $display("FAIL inflight_alloc got ok=%0b f=%0b s=%0d u=%0d exp f=0 s=0 u=5",
                     ok, rsp_fail, rsp_wg_slot_id, rsp_cu_wf_used);
        else n_pass++;
        inflight_tbl_id = 3'd1;
        // this edge both commits the write and samples the same entry
        @(posedge clk); #1;
        n_total++;
        if (inflight_free_count !== UW'(old_free))
            $display("FAIL inflight_rdw got %0d exp old %0d", inflight_free_count, old_free);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (inflight_free_count !== UW'(35))
            $display("FAIL inflight_read got %0d exp 35", inflight_free_count);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok0, ok1, mf; int lat, ms, mu;
        time t0;
        model_op(1'b0, 40, 400, 2, mf, ms, mu);
        do_req(1'b0, 40, 400, 2, ok0, lat);
        t0 = acc_time;
        model_op(1'b0, 40, 401, 2, mf, ms, mu);
        do_req(1'b0, 40, 401, 2, ok1, lat);
        n_total++;
        if (!ok0 || !ok1 || (acc_time - t0) != 40)
            $display("FAIL b2b_spacing got ok=%0b%0b dt=%0t exp dt=40ns (4 cycles)", ok0, ok1, acc_time - t0);
        else n_pass++;
        n_total++;
        if ({rsp_fail, rsp_wg_slot_id, rsp_cu_wf_used} !== {1'b0, SLW'(1), UW'(4)})
            $display("FAIL b2b_rsp got f=%0b s=%0d u=%0d exp f=0 s=1 u=4", rsp_fail, rsp_wg_slot_id, rsp_cu_wf_used);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if ({rsp_valid, rsp_wg_slot_id, rsp_cu_wf_used} !== {1'b0, SLW'(1), UW'(4)})
            $display("FAIL rsp_hold got v=%0b s=%0d u=%0d exp v=0 s=1 u=4", rsp_valid, rsp_wg_slot_id, rsp_cu_wf_used);
        else n_pass++;
    endtask

    task automatic test_random();
        bit ok, op, ef; int lat, es, eu, cu, wg, cn, g;
        for (int i = 0; i < 150; i++) begin
            op = ($urandom_range(0, 9) < 4);
            wg = 600 + $urandom_range(0, 47);
            cu = 16 + $urandom_range(0, 11);
            if (op && m_wv[wg] && $urandom_range(0, 3) != 0) cu = m_wcu[wg];
            cn = $urandom_range(0, 12);
            g  = $urandom_range(0, NGR - 1);
            model_op(op, cu, wg, cn, ef, es, eu);
            do_req(op, cu, wg, cn, ok, lat);
            n_total++;
            if (!ok || lat != 2 || {rsp_fail, rsp_wg_slot_id, rsp_cu_wf_used} !== {ef, SLW'(es), UW'(eu)})
                $display("FAIL rand[%0d] op=%0b cu=%0d wg=%0d cnt=%0d got ok=%0b lat=%0d f=%0b s=%0d u=%0d exp f=%0b s=%0d u=%0d",
                         i, op, cu, wg, cn, ok, lat, rsp_fail, rsp_wg_slot_id, rsp_cu_wf_used, ef, es, eu);
            else n_pass++;
            inflight_tbl_id = TW'(g);
            @(posedge clk); @(posedge clk); #1;
            n_total++;
            if (inflight_free_count !== UW'(m_infl[g]))
                $display("FAIL rand_inflight[%0d] grp=%0d got %0d exp %0d", i, g, inflight_free_count, m_infl[g]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midop();
        bit ok, mf, seen = 1'b0; int lat, ms, mu, guard = 0;
        model_op(1'b0, 12, 500, 3, mf, ms, mu);
        do_req(1'b0, 12, 500, 3, ok, lat);
        n_total++;
        if (!ok || {rsp_fail, rsp_wg_slot_id, rsp_cu_wf_used} !== {1'b0, SLW'(0), UW'(3)})
            $display("FAIL midop_pre got ok=%0b f=%0b s=%0d u=%0d exp f=0 s=0 u=3",
                     ok, rsp_fail, rsp_wg_slot_id, rsp_cu_wf_used);
        else n_pass++;
        req_valid = 1'b1; req_op = 1'b0; req_cu_id = CUW'(12); req_wg_id = WGW'(501); req_wf_count = CW'(2);
        while (req_ready !== 1'b1 && guard < 50) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1 req_valid = 1'b0;   // accepted, now in READ
        @(posedge clk); #1 rst = 1'b1;         // now in CALC
        repeat (3) begin @(posedge clk); #1; if (rsp_valid !== 1'b0) seen = 1'b1; end
        n_total++;
        if ({init_done, req_ready, rsp_valid} !== 3'b000)
            $display("FAIL midop_in_reset got id=%0b rdy=%0b v=%0b exp 000", init_done, req_ready, rsp_valid);
        else n_pass++;
        rst = 1'b0;
        guard = 0;
        while (init_done !== 1'b1 && guard < 1100) begin
            @(posedge clk); #1; guard++;
            if (rsp_valid !== 1'b0) seen = 1'b1;
        end
        n_total++;
        if (guard != 1024 || seen)
            $display("FAIL midop_rerun got sweep=%0d rsp_seen=%0b exp sweep=1024 rsp_seen=0", guard, seen);
        else n_pass++;
        model_clear();
        model_op(1'b1, 12, 500, 0, mf, ms, mu);
        do_req(1'b1, 12, 500, 0, ok, lat);
        n_total++;
        if (!ok || {rsp_fail, rsp_wg_slot_id, rsp_cu_wf_used} !== {1'b1, SLW'(0), UW'(0)})
            $display("FAIL midop_stale_dealloc got ok=%0b f=%0b s=%0d u=%0d exp f=1 s=0 u=0",
                     ok, rsp_fail, rsp_wg_slot_id, rsp_cu_wf_used);
        else n_pass++;
        model_op(1'b0, 12, 501, 2, mf, ms, mu);
        do_req(1'b0, 12, 501, 2, ok, lat);
        n_total++;
        if (!ok || {rsp_fail, rsp_wg_slot_id, rsp_cu_wf_used} !== {1'b0, SLW'(0), UW'(2)})
            $display("FAIL midop_realloc got ok=%0b f=%0b s=%0d u=%0d exp f=0 s=0 u=2",
                     ok, rsp_fail, rsp_wg_slot_id, rsp_cu_wf_used);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_alloc_basic();
        test_dealloc();
        test_capacity();
        test_inflight();
        test_back_to_back();
        test_random();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
